// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader for the CPU instruction memory.
// Frame = length byte (N-1), 4*N big-endian payload bytes, XOR checksum byte.
// Words are written one per cycle through an active-low write enable, and the
// CPU is held in reset until a load finishes with a matching checksum.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rstd,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              im_wren,
  output logic              cpu_rstd,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [ADDR_W-1:0]   r_len;
  logic [ADDR_W-1:0]   r_idx;
  logic [1:0]          r_bcnt;
  // Only the first three bytes of a word need storage; the fourth arrives
  // on the same edge the full word is registered into im_wdata.
  logic [23:0]         r_word;
  logic [7:0]          r_acc;

  logic                r_in_ready;
  logic [ADDR_W-1:0]   r_im_addr;
  logic [31:0]         r_im_wdata;
  logic                r_im_wren;
  logic                r_cpu_rstd;
  logic                r_busy;
  logic                r_done;
  logic                r_error;

  logic                w_xfer;
  logic                w_last_word;
  logic                w_next_busy;

  assign w_xfer      = in_valid & r_in_ready;
  assign w_last_word = (r_idx == r_len);
  assign w_next_busy = (w_next == S_LEN) || (w_next == S_DATA) ||
                       (w_next == S_WRITE) || (w_next == S_CSUM);

  assign in_ready = r_in_ready;
  assign im_addr  = r_im_addr;
  assign im_wdata = r_im_wdata;
  assign im_wren  = r_im_wren;
  assign cpu_rstd = r_cpu_rstd;
  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;

  // Next-state selection; start is only looked at in the non-busy states.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) w_next = S_LEN;
      end
      S_LEN: begin
        if (w_xfer) w_next = S_DATA;
      end
      S_DATA: begin
        if (w_xfer && (r_bcnt == 2'd3)) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_next = w_last_word ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (w_xfer) w_next = (in_data == r_acc) ? S_DONE : S_ERR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, datapath and outputs; outputs are registered from the next state so
  // they line up with the state they describe without any input-to-output path.
  always_ff @(posedge clk or posedge rstd) begin
    if (rstd) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_idx      <= '0;
      r_bcnt     <= '0;
      r_word     <= '0;
      r_acc      <= '0;
      r_in_ready <= 1'b0;
      r_im_addr  <= '0;
      r_im_wdata <= '0;
      r_im_wren  <= 1'b1;
      r_cpu_rstd <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next == S_LEN) || (w_next == S_DATA) || (w_next == S_CSUM);
      r_busy     <= w_next_busy;
      r_done     <= (w_next == S_DONE);
      r_error    <= (w_next == S_ERR);
      r_cpu_rstd <= (w_next == S_DONE);
      r_im_wren  <= (w_next != S_WRITE);

      case (r_state)
        S_LEN: begin
          if (w_xfer) begin
            r_len  <= ADDR_W'(in_data);
            r_idx  <= '0;
            r_bcnt <= '0;
            r_acc  <= '0;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_word <= {r_word[15:0], in_data};
            r_acc  <= r_acc ^ in_data;
            r_bcnt <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) begin
              r_im_addr  <= r_idx;
              r_im_wdata <= {r_word, in_data};
            end
          end
        end
        S_WRITE: begin
          if (!w_last_word) r_idx <= r_idx + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized frames,
// compared against a frame-level model of expected writes and final status.
module tb_imem_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rstd;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          im_wren;
  logic          cpu_rstd;
  logic          busy;
  logic          done;
  logic          error;

  imem_loader #(.ADDR_W(AW)) dut (
    .clk      (clk),
    .rstd     (rstd),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .im_wren  (im_wren),
    .cpu_rstd (cpu_rstd),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int nwrites = 0;
  logic [AW+31:0] expq[$];
  logic [31:0]    fw[256];

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every write cycle must match the next expected (addr, word) and stall input.
  always @(negedge clk) begin
    if (im_wren === 1'b0) begin
      logic [AW+31:0] e;
      nwrites++;
      chk("write_in_ready", {63'd0, in_ready}, 64'd0);
      checks++;
      assert (expq.size() > 0) else begin
        errors++;
        $error("FAIL extra_write observed=addr %0h data %h expected=no write", im_addr, im_wdata);
      end
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("write_addr_data", {24'd0, im_addr, im_wdata}, {24'd0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
    chk({tag, "_im_wren"},  {63'd0, im_wren},  64'd1);
    chk({tag, "_im_addr"},  {56'd0, im_addr},  64'd0);
    chk({tag, "_im_wdata"}, {32'd0, im_wdata}, 64'd0);
    chk({tag, "_cpu_rstd"}, {63'd0, cpu_rstd}, 64'd0);
    chk({tag, "_busy"},     {63'd0, busy},     64'd0);
    chk({tag, "_done"},     {63'd0, done},     64'd0);
    chk({tag, "_error"},    {63'd0, error},    64'd0);
  endtask

  // Present a byte after an optional idle gap and return once it has transferred.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    guard    = 0;
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        tick();
        break;
      end
      guard++;
      if (guard > 50) begin
        checks++;
        errors++;
        $error("FAIL send_timeout observed=in_ready low 50 cycles expected=byte %h accepted", b);
        break;
      end
      tick();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Send an n-word frame from fw[], optionally with a corrupted checksum,
  // random gaps up to gapmax, and start held high during payload byte start_at.
  task automatic run_frame(input int n, input bit bad, input int gapmax,
                           input int start_at, output int cycles);
    logic [7:0] c;
    logic [7:0] b;
    int         c0;
    int         guard;
    c = 8'h00;
    for (int k = 0; k < n; k++) expq.push_back({AW'(k), fw[k]});
    pulse_start();
    c0 = cyc;
    chk("enter_len_cpu_rstd", {63'd0, cpu_rstd}, 64'd0);
    chk("enter_len_busy",     {63'd0, busy},     64'd1);
    chk("enter_len_done",     {63'd0, done},     64'd0);
    chk("enter_len_error",    {63'd0, error},    64'd0);
    send_byte(8'(n - 1), (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 4; j++) begin
        b = 8'(fw[k] >> (8 * (3 - j)));
        c = c ^ b;
        if (4 * k + j == start_at) start = 1'b1;
        send_byte(b, (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
        start = 1'b0;
      end
    end
    send_byte(c ^ (bad ? 8'h01 : 8'h00), (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
    in_valid = 1'b0;
    guard = 0;
    forever begin
      @(negedge clk);
      if (done === 1'b1 || error === 1'b1 || guard > 20) break;
      guard++;
    end
    cycles = cyc - c0;
    chk("frame_done",     {63'd0, done},     {63'd0, !bad});
    chk("frame_error",    {63'd0, error},    {63'd0, bad});
    chk("frame_cpu_rstd", {63'd0, cpu_rstd}, {63'd0, !bad});
    chk("frame_busy",     {63'd0, busy},     64'd0);
    chk("frame_in_ready", {63'd0, in_ready}, 64'd0);
    chk("frame_pending_writes", 64'(expq.size()), 64'd0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    int w0;
    rstd     = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) tick();
    check_reset_outputs("reset");
    rstd = 1'b0;
    repeat (2) tick();
    chk("idle_busy", {63'd0, busy}, 64'd0);

    // Single word: 04 22 00 05, checksum 0x23, minimum duration 1+5+1 cycles.
    fw[0] = 32'h04220005;
    w0 = nwrites;
    run_frame(1, 1'b0, 0, -1, cycles);
    chk("single_cycles", 64'(cycles), 64'd7);
    chk("single_nwrites", 64'(nwrites - w0), 64'd1);

    // Three words with a one-cycle gap before every byte.
    fw[0] = 32'hDEADBEEF; fw[1] = 32'h01234567; fw[2] = 32'h89ABCDEF;
    w0 = nwrites;
    for (int k = 0; k < 3; k++) expq.push_back({AW'(k), fw[k]});
    begin
      logic [7:0] c;
      logic [7:0] b;
      c = 8'h00;
      pulse_start();
      send_byte(8'h02, 1);
      for (int k = 0; k < 3; k++)
        for (int j = 0; j < 4; j++) begin
          b = 8'(fw[k] >> (8 * (3 - j)));
          c = c ^ b;
          send_byte(b, 1);
        end
      send_byte(c, 1);
      in_valid = 1'b0;
      @(negedge clk);
      chk("toggle_done", {63'd0, done}, 64'd1);
      chk("toggle_cpu_rstd", {63'd0, cpu_rstd}, 64'd1);
      tick();
    end
    chk("toggle_nwrites", 64'(nwrites - w0), 64'd3);

    // Bad checksum on two words, then a good reload.
    fw[0] = 32'hCAFEF00D; fw[1] = 32'h00000001;
    w0 = nwrites;
    run_frame(2, 1'b1, 0, -1, cycles);
    chk("bad_nwrites", 64'(nwrites - w0), 64'd2);
    run_frame(2, 1'b0, 0, -1, cycles);

    // Full memory, word value = address, valid held high: last address 0xFF.
    for (int k = 0; k < 256; k++) fw[k] = 32'(k);
    w0 = nwrites;
    run_frame(256, 1'b0, 0, -1, cycles);
    chk("full_cycles", 64'(cycles), 64'(1 + 5 * 256 + 1));
    chk("full_nwrites", 64'(nwrites - w0), 64'd256);
    chk("full_last_addr", {56'd0, im_addr}, 64'hFF);

    // Reset after the 2nd byte of word 1: word 0 written, word 1 never.
    fw[0] = 32'h11223344; fw[1] = 32'h55667788;
    w0 = nwrites;
    expq.push_back({AW'(0), fw[0]});
    pulse_start();
    send_byte(8'h01, 0);
    for (int j = 0; j < 4; j++) send_byte(8'(fw[0] >> (8 * (3 - j))), 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    in_valid = 1'b0;
    rstd = 1'b1;
    #1;
    check_reset_outputs("midreset");
    tick();
    rstd = 1'b0;
    repeat (3) tick();
    chk("midreset_nwrites", 64'(nwrites - w0), 64'd1);
    fw[0] = 32'hA5A5_0F0F;
    run_frame(1, 1'b0, 0, -1, cycles);

    // start held during a payload byte of word 0 is ignored.
    fw[0] = 32'h01020304; fw[1] = 32'h05060708;
    w0 = nwrites;
    run_frame(2, 1'b0, 0, 2, cycles);
    chk("start_in_data_nwrites", 64'(nwrites - w0), 64'd2);

    // Randomized frames with gaps and random checksum corruption.
    for (int r = 0; r < 6; r++) begin
      int n;
      bit bad;
      n   = int'($urandom_range(1, 8));
      bad = 1'($urandom_range(0, 1));
      for (int k = 0; k < n; k++) fw[k] = $urandom;
      w0 = nwrites;
      run_frame(n, bad, 2, -1, cycles);
      chk("rand_nwrites", 64'(nwrites - w0), 64'(n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
